// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer
//
// Frames bytes from the UART RX FIFO into ALU operations and returns the
// results through the UART TX FIFO. A frame is three bytes in this order:
// operand A, operand B, opcode. The sequencer registers them onto the ALU
// inputs, waits one cycle for the ALU to settle, registers the result and
// pushes it to the TX FIFO.
//
// A frame that stalls between bytes for TIMEOUT_CYC cycles, or that carries
// an opcode outside the supported set, is dropped with a one-cycle o_error
// pulse, and the sequencer goes back to waiting for operand A.
//
// FIFO handshake: the RX FIFO is first-word-fall-through. rx_data is valid
// whenever rx_empty=0, and rd_uart pops the head word at the end of the
// cycle in which it is high. wr_uart pushes w_data at the end of the cycle
// in which it is high. rd_uart is only raised when rx_empty=0 and wr_uart
// only when tx_full=0, so each strobe completes in the cycle it is asserted.
// Both strobes are combinational so a pop or push takes effect in the same
// cycle.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   rx_empty    RX FIFO empty flag
//   rx_data     RX FIFO head word
//   rd_uart     RX FIFO pop strobe
//   tx_full     TX FIFO full flag
//   wr_uart     TX FIFO push strobe
//   w_data      TX FIFO write data (registered ALU result)
//   alu_a       ALU operand A (registered)
//   alu_b       ALU operand B (registered)
//   alu_op      ALU opcode (registered)
//   alu_result  ALU combinational result
//   o_busy      high whenever a frame is in progress (state != S_GET_A)
//   o_error     one-cycle pulse on timeout or invalid opcode
//   dbg_state   current FSM state encoding

module uart_alu_sequencer #(
    parameter int NB_DATA     = 8,
    parameter int NB_CODE     = 6,
    parameter int NB_STATE    = 3,
    parameter int NB_TOUT     = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_empty,
    input  logic [NB_DATA-1:0]  rx_data,
    output logic                rd_uart,
    input  logic                tx_full,
    output logic                wr_uart,
    output logic [NB_DATA-1:0]  w_data,
    output logic [NB_DATA-1:0]  alu_a,
    output logic [NB_DATA-1:0]  alu_b,
    output logic [NB_CODE-1:0]  alu_op,
    input  logic [NB_DATA-1:0]  alu_result,
    output logic                o_busy,
    output logic                o_error,
    output logic [NB_STATE-1:0] dbg_state
);

    typedef enum logic [NB_STATE-1:0] {
        S_GET_A  = 3'd0,
        S_GET_B  = 3'd1,
        S_GET_OP = 3'd2,
        S_EXEC   = 3'd3,
        S_SEND   = 3'd4
    } state_t;

    // Last counter value before a waiting state gives up on the frame.
    localparam logic [NB_TOUT-1:0] TOUT_LAST = NB_TOUT'(TIMEOUT_CYC - 1);

    state_t              state;
    state_t              state_nxt;
    logic [NB_TOUT-1:0]  cnt;
    logic [NB_TOUT-1:0]  cnt_nxt;
    logic [NB_DATA-1:0]  alu_a_nxt;
    logic [NB_DATA-1:0]  alu_b_nxt;
    logic [NB_CODE-1:0]  alu_op_nxt;
    logic [NB_DATA-1:0]  w_data_nxt;
    logic                error_nxt;
    logic [NB_CODE-1:0]  op_field;

    // Only the low NB_CODE bits of the opcode byte carry the opcode.
    assign op_field = rx_data[NB_CODE-1:0];

    function automatic logic is_valid_op(input logic [NB_CODE-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            6'b100000,  // ADD
            6'b100010,  // SUB
            6'b100100,  // AND
            6'b100101,  // OR
            6'b100110,  // XOR
            6'b100111,  // NOR
            6'b000011,  // SRA
            6'b000010:  // SRL
                ok = 1'b1;
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_GET_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            w_data  <= '0;
            o_error <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            alu_a   <= alu_a_nxt;
            alu_b   <= alu_b_nxt;
            alu_op  <= alu_op_nxt;
            w_data  <= w_data_nxt;
            o_error <= error_nxt;
        end
    end

    // Next state, strobes and register updates
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        alu_a_nxt  = alu_a;
        alu_b_nxt  = alu_b;
        alu_op_nxt = alu_op;
        w_data_nxt = w_data;
        error_nxt  = 1'b0;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;

        case (state)
            S_GET_A: begin
                // Idle: no timeout while waiting for a frame to start.
                if (!rx_empty) begin
                    rd_uart   = 1'b1;
                    alu_a_nxt = rx_data;
                    cnt_nxt   = '0;
                    state_nxt = S_GET_B;
                end
            end

            S_GET_B: begin
                if (!rx_empty) begin
                    rd_uart   = 1'b1;
                    alu_b_nxt = rx_data;
                    cnt_nxt   = '0;
                    state_nxt = S_GET_OP;
                end else if (cnt == TOUT_LAST) begin
                    // Operand A stays in its register but is no longer part
                    // of any frame.
                    error_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_GET_A;
                end else begin
                    cnt_nxt = cnt + NB_TOUT'(1);
                end
            end

            S_GET_OP: begin
                if (!rx_empty) begin
                    // The opcode byte is consumed whether or not it is valid.
                    rd_uart = 1'b1;
                    cnt_nxt = '0;
                    if (is_valid_op(op_field)) begin
                        alu_op_nxt = op_field;
                        state_nxt  = S_EXEC;
                    end else begin
                        error_nxt = 1'b1;
                        state_nxt = S_GET_A;
                    end
                end else if (cnt == TOUT_LAST) begin
                    error_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_GET_A;
                end else begin
                    cnt_nxt = cnt + NB_TOUT'(1);
                end
            end

            S_EXEC: begin
                // ALU inputs were registered last cycle, so the result is
                // settled now.
                w_data_nxt = alu_result;
                state_nxt  = S_SEND;
            end

            S_SEND: begin
                // TX backpressure is waited out with no timeout.
                if (!tx_full) begin
                    wr_uart   = 1'b1;
                    state_nxt = S_GET_A;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = S_GET_A;
            end
        endcase
    end

    assign o_busy    = (state != S_GET_A);
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer with a FWFT RX FIFO model, an
// unbounded TX sink and a combinational ALU model. Timeout shortened to 16.

module tb_uart_alu_sequencer;

  localparam int NB_DATA  = 8;
  localparam int NB_CODE  = 6;
  localparam int NB_STATE = 3;
  localparam int TOUT     = 16;

  logic                clk;
  logic                reset;
  logic                rx_empty;
  logic [NB_DATA-1:0]  rx_data;
  logic                rd_uart;
  logic                tx_full;
  logic                wr_uart;
  logic [NB_DATA-1:0]  w_data;
  logic [NB_DATA-1:0]  alu_a;
  logic [NB_DATA-1:0]  alu_b;
  logic [NB_CODE-1:0]  alu_op;
  logic [NB_DATA-1:0]  alu_result;
  logic                o_busy;
  logic                o_error;
  logic [NB_STATE-1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  uart_alu_sequencer #(
    .NB_DATA(NB_DATA), .NB_CODE(NB_CODE), .NB_STATE(NB_STATE),
    .NB_TOUT(16), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data),
    .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .o_busy(o_busy), .o_error(o_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ALU model ----------------
  always_comb begin
    alu_result = '0;
    case (alu_op)
      6'b100000: alu_result = alu_a + alu_b;
      6'b100010: alu_result = alu_a - alu_b;
      6'b100100: alu_result = alu_a & alu_b;
      6'b100101: alu_result = alu_a | alu_b;
      6'b100110: alu_result = alu_a ^ alu_b;
      6'b100111: alu_result = ~(alu_a | alu_b);
      6'b000011: alu_result = NB_DATA'($signed(alu_a) >>> alu_b);
      6'b000010: alu_result = alu_a >> alu_b;
      default:   alu_result = '0;
    endcase
  end

  // ---------------- RX FIFO model (first-word-fall-through) ----------------
  logic [NB_DATA-1:0] rx_mem [0:255];
  int wptr = 0;
  int rptr = 0;

  assign rx_empty = (rptr == wptr);
  assign rx_data  = rx_mem[rptr[7:0]];

  always @(posedge clk) begin
    if (rd_uart && (rptr != wptr)) rptr <= rptr + 1;
  end

  // Driver: called at posedge+1
  task automatic push_byte(input logic [NB_DATA-1:0] b);
    rx_mem[wptr[7:0]] = b;
    wptr = wptr + 1;
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    push_byte(a);
    push_byte(b);
    push_byte(op);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  int rd_cnt      = 0;
  int err_cnt     = 0;
  int viol        = 0;
  int last_rd_cyc = 0;
  int last_err_cyc = 0;
  logic [NB_DATA-1:0] exp_q[$];
  logic [NB_DATA-1:0] wr_q[$];
  int                 wr_cyc_q[$];

  always @(negedge clk) begin
    if (rd_uart) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      if (rx_empty) viol++;
    end
    if (wr_uart) begin
      wr_q.push_back(w_data);
      wr_cyc_q.push_back(cyc);
      if (tx_full) viol++;
    end
    if (rd_uart && wr_uart) viol++;
    if (o_error) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  task automatic wait_wr(input int target, input int budget);
    for (int i = 0; i < budget && wr_q.size() < target; i++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    tx_full = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_uart, wr_uart, o_busy, o_error} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {rd_uart, wr_uart, o_busy, o_error});
    end
    n_checks++;
    if ({alu_a, alu_b, alu_op, w_data} !== 30'd0) begin
      n_fail++; $display("FAIL reset_regs: got a=%h b=%h op=%h w=%h expected all 0", alu_a, alu_b, alu_op, w_data);
    end
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int wr0, rd0, err0;
    wr0 = wr_q.size(); rd0 = rd_cnt; err0 = err_cnt;
    step();
    push_frame(8'h03, 8'h03, 8'h20);
    exp_q.push_back(8'h06);
    wait_wr(wr0 + 1, 40);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rd_cnt - rd0 !== 3) begin
      n_fail++; $display("FAIL basic_pops: got %0d expected 3", rd_cnt - rd0);
    end
    n_checks++;
    if (wr_q.size() - wr0 !== 1) begin
      n_fail++; $display("FAIL basic_writes: got %0d expected 1", wr_q.size() - wr0);
    end else begin
      n_checks++;
      if (wr_q[wr0] !== exp_q.pop_front()) begin
        n_fail++; $display("FAIL basic_wdata: got %h expected 06", wr_q[wr0]);
      end
      n_checks++;
      if (wr_cyc_q[wr0] !== last_rd_cyc + 2) begin
        n_fail++; $display("FAIL basic_latency: got wr cycle %0d expected %0d", wr_cyc_q[wr0], last_rd_cyc + 2);
      end
    end
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== {8'h03, 8'h03, 6'b100000}) begin
      n_fail++; $display("FAIL basic_alu_regs: got a=%h b=%h op=%b expected 03 03 100000", alu_a, alu_b, alu_op);
    end
    n_checks++;
    if (err_cnt - err0 !== 0) begin
      n_fail++; $display("FAIL basic_error: got %0d pulses expected 0", err_cnt - err0);
    end
  endtask

  task automatic test_backpressure();
    int wr0, busy_low, rel_cyc;
    wr0 = wr_q.size(); busy_low = 0;
    step();
    tx_full = 1'b1;
    push_frame(8'h03, 8'h03, 8'h20);
    step();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!o_busy) busy_low++;
    end
    n_checks++;
    if (wr_q.size() - wr0 !== 0) begin
      n_fail++; $display("FAIL bp_write_while_full: got %0d writes expected 0", wr_q.size() - wr0);
    end
    n_checks++;
    if (busy_low !== 0) begin
      n_fail++; $display("FAIL bp_busy: got %0d idle cycles expected 0", busy_low);
    end
    step();
    tx_full = 1'b0;
    rel_cyc = cyc;
    repeat (4) @(negedge clk);
    n_checks++;
    if (wr_q.size() - wr0 !== 1) begin
      n_fail++; $display("FAIL bp_writes: got %0d expected 1", wr_q.size() - wr0);
    end else begin
      n_checks++;
      if (wr_q[wr0] !== 8'h06 || wr_cyc_q[wr0] !== rel_cyc) begin
        n_fail++; $display("FAIL bp_release: got data %h cycle %0d expected 06 cycle %0d", wr_q[wr0], wr_cyc_q[wr0], rel_cyc);
      end
    end
  endtask

  task automatic test_timeout();
    int wr0, err0;
    wr0 = wr_q.size(); err0 = err_cnt;
    step();
    push_byte(8'h05);
    repeat (TOUT + 10) @(negedge clk);
    n_checks++;
    if (err_cnt - err0 !== 1) begin
      n_fail++; $display("FAIL tout_pulses: got %0d expected 1", err_cnt - err0);
    end
    n_checks++;
    if (last_err_cyc !== last_rd_cyc + TOUT + 1) begin
      n_fail++; $display("FAIL tout_timing: got error cycle %0d expected %0d", last_err_cyc, last_rd_cyc + TOUT + 1);
    end
    n_checks++;
    if (o_busy !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL tout_idle: got busy=%b state=%0d expected 0 0", o_busy, dbg_state);
    end
    step();
    push_frame(8'h07, 8'h02, 8'h22);
    wait_wr(wr0 + 1, 40);
    n_checks++;
    if (wr_q.size() - wr0 !== 1 || wr_q[wr0] !== 8'h05) begin
      n_fail++; $display("FAIL tout_next_frame: got %0d writes first %h expected 1 write of 05",
                         wr_q.size() - wr0, (wr_q.size() > wr0) ? wr_q[wr0] : 8'hxx);
    end
  endtask

  task automatic test_invalid_op();
    int wr0, rd0, err0;
    wr0 = wr_q.size(); rd0 = rd_cnt; err0 = err_cnt;
    step();
    push_frame(8'h0A, 8'h01, 8'h3F);
    repeat (12) @(negedge clk);
    n_checks++;
    if (rd_cnt - rd0 !== 3 || wr_q.size() - wr0 !== 0 || err_cnt - err0 !== 1) begin
      n_fail++; $display("FAIL inv_frame: got pops=%0d writes=%0d errors=%0d expected 3 0 1",
                         rd_cnt - rd0, wr_q.size() - wr0, err_cnt - err0);
    end
    n_checks++;
    if (alu_op !== 6'b100010) begin
      n_fail++; $display("FAIL inv_op_hold: got %b expected 100010", alu_op);
    end
    step();
    push_frame(8'hF0, 8'h0F, 8'h24);
    wait_wr(wr0 + 1, 40);
    n_checks++;
    if (wr_q.size() - wr0 !== 1 || wr_q[wr0] !== 8'h00) begin
      n_fail++; $display("FAIL inv_next_frame: got %0d writes first %h expected 1 write of 00",
                         wr_q.size() - wr0, (wr_q.size() > wr0) ? wr_q[wr0] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid_frame();
    int wr0;
    wr0 = wr_q.size();
    step();
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1 || dbg_state !== 3'd2) begin
      n_fail++; $display("FAIL mid_busy: got busy=%b state=%0d expected 1 2", o_busy, dbg_state);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({rd_uart, wr_uart, o_busy, o_error} !== 4'b0000 || {alu_a, alu_b, alu_op, w_data} !== 30'd0) begin
      n_fail++; $display("FAIL mid_async_reset: got strobes=%b a=%h b=%h op=%h w=%h expected all 0",
                         {rd_uart, wr_uart, o_busy, o_error}, alu_a, alu_b, alu_op, w_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (wr_q.size() - wr0 !== 0 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL mid_abandon: got writes=%0d state=%0d expected 0 0", wr_q.size() - wr0, dbg_state);
    end
    step();
    push_frame(8'h01, 8'h02, 8'h20);
    wait_wr(wr0 + 1, 40);
    n_checks++;
    if (wr_q.size() - wr0 !== 1 || wr_q[wr0] !== 8'h03) begin
      n_fail++; $display("FAIL mid_fresh_frame: got %0d writes first %h expected 1 write of 03",
                         wr_q.size() - wr0, (wr_q.size() > wr0) ? wr_q[wr0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int wr0, v0;
    logic [7:0] fa [6];
    logic [7:0] fb [6];
    logic [7:0] fo [6];
    logic [7:0] fr [6];
    // Opcode byte E0 checks that the upper two bits are ignored (ADD).
    fa = '{8'h10, 8'h50, 8'hCC, 8'hCC, 8'h80, 8'h0F};
    fb = '{8'h22, 8'h20, 8'hAA, 8'hAA, 8'h02, 8'hF0};
    fo = '{8'hE0, 8'h22, 8'h24, 8'h26, 8'h03, 8'h27};
    fr = '{8'h32, 8'h30, 8'h88, 8'h66, 8'hE0, 8'h00};
    wr0 = wr_q.size(); v0 = viol;
    step();
    for (int i = 0; i < 6; i++) begin
      push_frame(fa[i], fb[i], fo[i]);
      exp_q.push_back(fr[i]);
    end
    wait_wr(wr0 + 6, 100);
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_q.size() - wr0 !== 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 6", wr_q.size() - wr0);
    end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (wr0 + i < wr_q.size()) begin
        n_checks++;
        if (wr_q[wr0 + i] !== e) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, wr_q[wr0 + i], e);
        end
        if (i > 0) begin
          n_checks++;
          if (wr_cyc_q[wr0 + i] - wr_cyc_q[wr0 + i - 1] !== 5) begin
            n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 5", i,
                               wr_cyc_q[wr0 + i] - wr_cyc_q[wr0 + i - 1]);
          end
        end
      end
    end
    n_checks++;
    if (rptr !== wptr) begin
      n_fail++; $display("FAIL b2b_drain: got %0d bytes left expected 0", wptr - rptr);
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL protocol_strobes: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_invalid_op();
    test_reset_mid_frame();
    test_back_to_back();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Controller between the UART RX/TX FIFOs and the combinational ALU.
- Pops three bytes from the RX FIFO in order: operand A, operand B, opcode.
- Drives the ALU with them, captures the result and pushes it into the TX FIFO.
- Owns inter-byte timeout and opcode validation, so a lost or garbled frame never wedges the link.

Parameters:
NB_DATA, 8, data/operand/result width (UART byte width)
NB_CODE, 6, ALU opcode width (low NB_CODE bits of the opcode byte)
NB_STATE, 3, state register width
NB_TOUT, 16, timeout counter width
TIMEOUT_CYC, 50000, clk cycles allowed between bytes of one frame

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
rx_empty  input  1  RX FIFO empty flag
rx_data  input  NB_DATA  RX FIFO head word (first-word-fall-through, valid when rx_empty=0)
rd_uart  output  1  RX FIFO pop strobe, one cycle per byte
tx_full  input  1  TX FIFO full flag
wr_uart  output  1  TX FIFO push strobe, one cycle per result
w_data  output  NB_DATA  TX FIFO write data (registered result)
alu_a  output  NB_DATA  ALU operand A (registered)
alu_b  output  NB_DATA  ALU operand B (registered)
alu_op  output  NB_CODE  ALU opcode (registered)
alu_result  input  NB_DATA  ALU combinational result
o_busy  output  1  high whenever state != S_GET_A
o_error  output  1  one-cycle pulse on timeout or invalid opcode

Behaviour:
- Reset (reset=0, asynchronous): state=S_GET_A; alu_a=alu_b=w_data=0; alu_op=0; timeout counter=0; rd_uart=wr_uart=o_busy=o_error=0.
- rd_uart and wr_uart are combinational from state and FIFO flags (same-cycle pop/push). All other outputs are registered.
- S_GET_A (idle):
  - if rx_empty=0: rd_uart=1, alu_a<=rx_data, clear counter, go S_GET_B.
  - else hold. The counter does not run in this state.
- S_GET_B:
  - if rx_empty=0: rd_uart=1, alu_b<=rx_data, clear counter, go S_GET_OP.
  - else counter+1.
  - When counter==TIMEOUT_CYC-1: o_error=1 next cycle, go S_GET_A, alu_a unchanged (discarded logically).
- S_GET_OP:
  - if rx_empty=0: rd_uart=1, clear counter.
  - If rx_data[NB_CODE-1:0] is a valid opcode: alu_op<=it, go S_EXEC.
  - Else: alu_op unchanged, o_error=1 next cycle, go S_GET_A. The byte is consumed.
  - Same timeout rule as S_GET_B.
  - Upper bits of the opcode byte are ignored.
- Valid opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL. All others are invalid.
- S_EXEC: one cycle for ALU settling on the registered inputs; w_data<=alu_result; go S_SEND.
- S_SEND:
  - if tx_full=0: wr_uart=1, go S_GET_A.
  - else hold with wr_uart=0, with no timeout (backpressure is waited out indefinitely).
- Latency: the last byte popped at cycle N gives wr_uart at cycle N+2 when tx_full=0.
- A new frame may begin the cycle after wr_uart. Back-to-back frames must give one result per 5 cycles minimum with RX always non-empty.
- rd_uart is never asserted when rx_empty=1. wr_uart is never asserted when tx_full=1.
- At most one of rd_uart/wr_uart is high in any cycle.
- Reset mid-frame: partial frame abandoned, no write issued, and any bytes still in the RX FIFO are treated as a new frame start.
- Counter saturates by construction (cleared on each state exit). TIMEOUT_CYC must be < 2^NB_TOUT.
- Illegal state encoding: return to S_GET_A.

Test Plan:
- Feed 0x03, 0x03, 0x20 with tx_full=0 -> three rd_uart pulses; alu_a=0x03, alu_b=0x03, alu_op=6'b100000; with the ALU model, wr_uart pulses once with w_data=0x06 two cycles after the third pop; o_error stays 0.
- Same frame with tx_full=1 held 20 cycles, then released -> no wr_uart while full; single wr_uart with w_data=0x06 the cycle tx_full drops; o_busy high throughout.
- Feed 0x05 only, then RX empty for TIMEOUT_CYC cycles (bench uses TIMEOUT_CYC=16) -> o_error pulse exactly once after 16 cycles; state back to S_GET_A; the next 0x07, 0x02, 0x22 frame yields w_data=0x05.
- Feed 0x0A, 0x01, 0x3F (invalid opcode) -> three pops, no wr_uart, one o_error pulse; the following valid frame 0xF0, 0x0F, 0x24 yields w_data=0x00.
- Assert reset low asynchronously after the second byte of a frame -> all outputs 0 immediately; after release, a fresh 0x01, 0x02, 0x20 frame yields 0x03.
- Preload 6 frames (18 bytes) in RX with tx_full=0 -> 6 results in order, consecutive wr_uart pulses exactly 5 cycles apart, no pops while RX is empty.
